// File: rtl/a_mover.sv
// a_mover: moves the "A" marker across a 10x6 tile grid in response to
// W/A/S/D key events. A cooldown timer limits the move rate. One request
// that arrives during the cooldown is remembered and evaluated when the
// cooldown expires. Rejected moves produce a bump pulse.
module a_mover #(
    parameter logic [23:0] MOVE_COOLDOWN = 24'd5_000_000,
    parameter logic [3:0]  INIT_H        = 4'd1,
    parameter logic [3:0]  INIT_V        = 4'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [8:0] last_change,
    input  logic       key_make,
    output logic [3:0] curAh,
    output logic [3:0] curAv,
    output logic       moved,
    output logic       bump
);

    // Direction index: 0 = W (up), 1 = S (down), 2 = A (left), 3 = D (right)
    localparam logic [8:0] CODE_W = 9'h01D;
    localparam logic [8:0] CODE_S = 9'h01B;
    localparam logic [8:0] CODE_A = 9'h01C;
    localparam logic [8:0] CODE_D = 9'h023;
    localparam logic [35:0] DIR_CODES = {CODE_D, CODE_A, CODE_S, CODE_W};

    localparam logic [4:0] H_MAX = 5'd9;
    localparam logic [4:0] V_MAX = 5'd5;

    typedef enum logic {
        IDLE,
        COOL
    } state_t;

    state_t      state_reg, state_next;
    logic [23:0] cnt_reg, cnt_next;
    logic [3:0]  held_reg, held_next;
    logic        pend_valid_reg, pend_valid_next;
    logic [1:0]  pend_dir_reg, pend_dir_next;
    logic [3:0]  h_reg, h_next;
    logic [3:0]  v_reg, v_next;
    logic        moved_reg, moved_next;
    logic        bump_reg, bump_next;

    logic [3:0]  key_hit;
    logic [3:0]  req_hot;
    logic        req;
    logic [1:0]  req_dir;

    logic        use_pend;
    logic [1:0]  eval_dir;
    logic [4:0]  tgt_h;
    logic [4:0]  tgt_v;
    logic        tgt_legal;
    logic        evaluate;

    // Per-direction key decode, held tracking and fresh-press detection.
    // A make on a key that is already held is a typematic repeat and does
    // not count as a request.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dir
            assign key_hit[gi]   = key_valid && (last_change == DIR_CODES[gi*9 +: 9]);
            assign held_next[gi] = key_hit[gi] ? key_make : held_reg[gi];
            assign req_hot[gi]   = key_hit[gi] && key_make && !held_reg[gi];
        end
    endgenerate

    // The four codes are distinct, so at most one req_hot bit is set.
    assign req     = |req_hot;
    assign req_dir = {req_hot[3] | req_hot[2], req_hot[3] | req_hot[1]};

    // The pending request takes priority over a new one when the cooldown ends.
    assign use_pend = (state_reg == COOL) && (cnt_reg == 24'd0) && pend_valid_reg;
    assign eval_dir = use_pend ? pend_dir_reg : req_dir;

    // Target tile and legality for the direction being evaluated this cycle.
    // Working in 5 bits makes an underflow land at 31, which fails the range
    // check instead of wrapping onto the grid.
    always_comb begin
        tgt_h = {1'b0, h_reg};
        tgt_v = {1'b0, v_reg};
        case (eval_dir)
            2'd0:    tgt_v = {1'b0, v_reg} - 5'd1;
            2'd1:    tgt_v = {1'b0, v_reg} + 5'd1;
            2'd2:    tgt_h = {1'b0, h_reg} - 5'd1;
            default: tgt_h = {1'b0, h_reg} + 5'd1;
        endcase
        tgt_legal = (tgt_h <= H_MAX) && (tgt_v <= V_MAX) &&
                    !(((tgt_h % 5'd3) != 5'd0) && (tgt_v[1:0] == 2'b00));
    end

    // Next-state logic: decide whether a request is evaluated this cycle,
    // then apply the common move-or-bump outcome.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        pend_valid_next = pend_valid_reg;
        pend_dir_next   = pend_dir_reg;
        h_next          = h_reg;
        v_next          = v_reg;
        moved_next      = 1'b0;
        bump_next       = 1'b0;
        evaluate        = 1'b0;

        case (state_reg)
            IDLE: begin
                evaluate = req;
            end
            COOL: begin
                if (cnt_reg != 24'd0) begin
                    cnt_next = cnt_reg - 24'd1;
                    if (req && !pend_valid_reg) begin
                        pend_valid_next = 1'b1;
                        pend_dir_next   = req_dir;
                    end
                end else if (pend_valid_reg) begin
                    // Any new request in this cycle is dropped.
                    pend_valid_next = 1'b0;
                    evaluate        = 1'b1;
                end else if (req) begin
                    evaluate = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (evaluate) begin
            if (tgt_legal) begin
                h_next     = tgt_h[3:0];
                v_next     = tgt_v[3:0];
                moved_next = 1'b1;
                cnt_next   = MOVE_COOLDOWN - 24'd1;
                state_next = COOL;
            end else begin
                bump_next  = 1'b1;
                state_next = IDLE;
            end
        end
    end

    // State and output registers, cleared immediately by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 24'd0;
            held_reg       <= 4'b0000;
            pend_valid_reg <= 1'b0;
            pend_dir_reg   <= 2'd0;
            h_reg          <= INIT_H;
            v_reg          <= INIT_V;
            moved_reg      <= 1'b0;
            bump_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            held_reg       <= held_next;
            pend_valid_reg <= pend_valid_next;
            pend_dir_reg   <= pend_dir_next;
            h_reg          <= h_next;
            v_reg          <= v_next;
            moved_reg      <= moved_next;
            bump_reg       <= bump_next;
        end
    end

    assign curAh = h_reg;
    assign curAv = v_reg;
    assign moved = moved_reg;
    assign bump  = bump_reg;

endmodule

// File: tb/tb_a_mover.sv
// Bench for a_mover. Four instances share the key inputs but have their own
// reset: 0 = cooldown 3 from (1,1), 1 = cooldown 3 from (0,5),
// 2 = cooldown 10 from (1,1), 3 = cooldown 1 from (1,1).
// Every cycle all instances are compared against a time-based model; the
// directed tables and hand sequences add fixed expected values.
module tb_a_mover;

    localparam logic [8:0] K_W = 9'h01D;
    localparam logic [8:0] K_S = 9'h01B;
    localparam logic [8:0] K_A = 9'h01C;
    localparam logic [8:0] K_D = 9'h023;

    logic       clk = 1'b0;
    logic [3:0] rst_n_v = 4'b0000;
    logic       key_valid = 1'b0;
    logic [8:0] last_change = 9'h000;
    logic       key_make = 1'b0;

    logic [3:0] ah [4];
    logic [3:0] av [4];
    logic       mv [4];
    logic       bp [4];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    a_mover #(.MOVE_COOLDOWN(24'd3), .INIT_H(4'd1), .INIT_V(4'd1)) u0 (
        .clk(clk), .rst_n(rst_n_v[0]), .key_valid(key_valid), .last_change(last_change),
        .key_make(key_make), .curAh(ah[0]), .curAv(av[0]), .moved(mv[0]), .bump(bp[0]));
    a_mover #(.MOVE_COOLDOWN(24'd3), .INIT_H(4'd0), .INIT_V(4'd5)) u1 (
        .clk(clk), .rst_n(rst_n_v[1]), .key_valid(key_valid), .last_change(last_change),
        .key_make(key_make), .curAh(ah[1]), .curAv(av[1]), .moved(mv[1]), .bump(bp[1]));
    a_mover #(.MOVE_COOLDOWN(24'd10), .INIT_H(4'd1), .INIT_V(4'd1)) u2 (
        .clk(clk), .rst_n(rst_n_v[2]), .key_valid(key_valid), .last_change(last_change),
        .key_make(key_make), .curAh(ah[2]), .curAv(av[2]), .moved(mv[2]), .bump(bp[2]));
    a_mover #(.MOVE_COOLDOWN(24'd1), .INIT_H(4'd1), .INIT_V(4'd1)) u3 (
        .clk(clk), .rst_n(rst_n_v[3]), .key_valid(key_valid), .last_change(last_change),
        .key_make(key_make), .curAh(ah[3]), .curAv(av[3]), .moved(mv[3]), .bump(bp[3]));

    // ---------------- reference model ----------------
    // A move evaluated in cycle m makes the next evaluation possible in cycle
    // m + cooldown; requests before that wait in a one-deep queue.
    int     MC_T [4] = '{3, 3, 10, 1};
    int     IH   [4] = '{1, 0, 1, 1};
    int     IV   [4] = '{1, 5, 1, 1};
    int     m_h  [4];
    int     m_v  [4];
    bit     m_held [4][4];
    int     m_pend [4][$];
    longint m_ready [4];
    bit     m_mv [4];
    bit     m_bp [4];
    longint cyc = 0;

    function automatic int dir_of(logic [8:0] c);
        case (c)
            K_W:     return 0;
            K_S:     return 1;
            K_A:     return 2;
            K_D:     return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit tile_ok(int h, int v);
        if (h < 0 || h > 9 || v < 0 || v > 5) return 1'b0;
        return !((h % 3 != 0) && (v % 4 == 0));
    endfunction

    task automatic model_try(int i, int d);
        int th, tv;
        th = m_h[i];
        tv = m_v[i];
        if (d == 0) tv = tv - 1;
        if (d == 1) tv = tv + 1;
        if (d == 2) th = th - 1;
        if (d == 3) th = th + 1;
        if (tile_ok(th, tv)) begin
            m_h[i] = th;
            m_v[i] = tv;
            m_mv[i] = 1'b1;
            m_ready[i] = cyc + longint'(MC_T[i]);
        end else begin
            m_bp[i] = 1'b1;
        end
    endtask

    task automatic model_cycle();
        int  d;
        bit  rq;
        int  pd;
        d = dir_of(last_change);
        for (int i = 0; i < 4; i++) begin
            m_mv[i] = 1'b0;
            m_bp[i] = 1'b0;
            if (!rst_n_v[i]) begin
                m_h[i] = IH[i];
                m_v[i] = IV[i];
                for (int k = 0; k < 4; k++) m_held[i][k] = 1'b0;
                m_pend[i].delete();
                m_ready[i] = 0;
            end else begin
                rq = 1'b0;
                if (key_valid && d >= 0) begin
                    rq = key_make && !m_held[i][d];
                    m_held[i][d] = key_make;
                end
                if (cyc < m_ready[i]) begin
                    if (rq && m_pend[i].size() == 0) m_pend[i].push_back(d);
                end else if (m_pend[i].size() != 0) begin
                    pd = m_pend[i].pop_front();
                    model_try(i, pd);
                end else if (rq) begin
                    model_try(i, d);
                end
            end
        end
        cyc = cyc + 1;
    endtask

    task automatic check_model(int i);
        logic [9:0] got, exp;
        got = {ah[i], av[i], mv[i], bp[i]};
        exp = {4'(m_h[i]), 4'(m_v[i]), m_mv[i], m_bp[i]};
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL model[%0d] cyc %0d: got h=%0d v=%0d moved=%0b bump=%0b, required h=%0d v=%0d moved=%0b bump=%0b",
                     i, cyc, got[9:6], got[5:2], got[1], got[0], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic step(input bit v, input logic [8:0] c, input bit mk);
        key_valid   = v;
        last_change = c;
        key_make    = mk;
        model_cycle();
        @(negedge clk);
        for (int i = 0; i < 4; i++) check_model(i);
        key_valid = 1'b0;
    endtask

    task automatic check_fixed(input string name, input int i, input int eh, input int ev,
                               input bit em, input bit eb);
        n_assert++;
        if (ah[i] !== 4'(eh) || av[i] !== 4'(ev) || mv[i] !== em || bp[i] !== eb) begin
            n_fail++;
            $display("FAIL %s: got h=%0d v=%0d moved=%0b bump=%0b, required h=%0d v=%0d moved=%0b bump=%0b",
                     name, ah[i], av[i], mv[i], bp[i], eh, ev, em, eb);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int       inst;
        bit       v;
        logic [8:0] code;
        bit       mk;
        int       eh;
        int       ev;
        bit       em;
        bit       eb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(int inst, bit v, logic [8:0] code, bit mk, int eh, int ev, bit em, bit eb);
        vec_t e;
        e.inst = inst; e.v = v; e.code = code; e.mk = mk;
        e.eh = eh; e.ev = ev; e.em = em; e.eb = eb;
        tbl.push_back(e);
    endtask

    initial begin
        int cur;
        logic [8:0] codes [6];
        codes = '{K_W, K_S, K_A, K_D, 9'h11D, 9'h029};

        // Instance 0, cooldown 3, start (1,1)
        add(0, 1, K_D, 1, 2, 1, 1, 0);
        add(0, 0, K_D, 0, 2, 1, 0, 0);
        add(0, 0, K_D, 0, 2, 1, 0, 0);
        add(0, 1, K_A, 1, 1, 1, 1, 0);
        add(0, 1, K_D, 0, 1, 1, 0, 0);
        add(0, 1, K_A, 0, 1, 1, 0, 0);
        add(0, 0, K_A, 0, 1, 1, 0, 0);
        add(0, 1, K_W, 1, 1, 1, 0, 1);
        add(0, 1, K_W, 0, 1, 1, 0, 0);
        add(0, 1, K_S, 1, 1, 2, 1, 0);
        add(0, 1, K_D, 1, 1, 2, 0, 0);
        add(0, 1, K_A, 1, 1, 2, 0, 0);
        add(0, 0, K_A, 0, 2, 2, 1, 0);
        add(0, 1, K_S, 0, 2, 2, 0, 0);
        add(0, 1, K_A, 0, 2, 2, 0, 0);
        add(0, 1, K_D, 0, 2, 2, 0, 0);
        add(0, 1, K_D, 1, 3, 2, 1, 0);
        add(0, 1, K_D, 1, 3, 2, 0, 0);
        add(0, 0, K_D, 0, 3, 2, 0, 0);
        add(0, 1, K_D, 1, 3, 2, 0, 0);
        add(0, 1, K_D, 0, 3, 2, 0, 0);
        add(0, 1, K_D, 1, 4, 2, 1, 0);
        add(0, 1, 9'h11D, 1, 4, 2, 0, 0);
        // Instance 1, cooldown 3, start (0,5)
        add(1, 1, K_S, 1, 0, 5, 0, 1);
        add(1, 1, K_A, 1, 0, 5, 0, 1);
        add(1, 1, K_D, 1, 1, 5, 1, 0);
        add(1, 1, K_W, 1, 1, 5, 0, 0);
        add(1, 0, K_W, 0, 1, 5, 0, 0);
        add(1, 0, K_W, 0, 1, 5, 0, 1);
        add(1, 1, K_A, 0, 1, 5, 0, 0);
        add(1, 1, K_A, 1, 0, 5, 1, 0);
        // Instance 3, cooldown 1: moves on consecutive cycles
        add(3, 1, K_D, 1, 2, 1, 1, 0);
        add(3, 1, K_S, 1, 2, 2, 1, 0);
        add(3, 1, K_A, 1, 1, 2, 1, 0);
        add(3, 1, K_W, 1, 1, 1, 1, 0);

        @(negedge clk);
        // Reset state of every instance
        step(0, 9'h000, 0);
        for (int i = 0; i < 4; i++) check_fixed("reset", i, IH[i], IV[i], 0, 0);

        cur = -1;
        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].inst != cur) begin
                rst_n_v = 4'b0000;
                step(0, 9'h000, 0);
                cur = tbl[k].inst;
                rst_n_v = 4'(1 << cur);
            end
            step(tbl[k].v, tbl[k].code, tbl[k].mk);
            $display("vec %0d inst %0d: valid=%0b code=%h make=%0b -> h=%0d v=%0d moved=%0b bump=%0b",
                     k, cur, tbl[k].v, tbl[k].code, tbl[k].mk, ah[cur], av[cur], mv[cur], bp[cur]);
            check_fixed($sformatf("vec%0d", k), cur, tbl[k].eh, tbl[k].ev, tbl[k].em, tbl[k].eb);
        end

        // Instance 2, cooldown 10: reset in the middle of the cooldown
        rst_n_v = 4'b0000;
        step(0, 9'h000, 0);
        rst_n_v = 4'b0100;
        step(1, K_D, 1);
        check_fixed("cool10_move", 2, 2, 1, 1, 0);
        step(0, 9'h000, 0);
        step(0, 9'h000, 0);
        step(0, 9'h000, 0);
        #2;
        rst_n_v[2] = 1'b0;
        #1;
        check_fixed("async_reset", 2, 1, 1, 0, 0);
        step(0, 9'h000, 0);
        rst_n_v[2] = 1'b1;
        step(1, K_D, 1);
        $display("post-reset make D: h=%0d v=%0d moved=%0b", ah[2], av[2], mv[2]);
        check_fixed("post_reset_move", 2, 2, 1, 1, 0);

        // Randomized traffic with occasional per-instance resets
        rst_n_v = 4'b1111;
        for (int n = 0; n < 1500; n++) begin
            bit v, mk;
            logic [8:0] c;
            for (int i = 0; i < 4; i++) rst_n_v[i] = ($urandom_range(0, 149) != 0);
            v  = ($urandom_range(0, 1) == 1);
            mk = ($urandom_range(0, 9) < 6);
            c  = codes[$urandom_range(0, 5)];
            step(v, c, mk);
            if (v)
                $display("rand %0d: code=%h make=%0b rst=%b -> A0(%0d,%0d) A1(%0d,%0d) A2(%0d,%0d) A3(%0d,%0d)",
                         n, c, mk, rst_n_v, ah[0], av[0], ah[1], av[1], ah[2], av[2], ah[3], av[3]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
